// File: rtl/fixed_point_pkg.sv
// Shared fixed-point formats for the arithmetic blocks.
// The format width W and fraction width F are set by macros; N = W + F.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

package fixed_point_pkg;
   localparam int W     = `FIXED_W;
   localparam int F     = `FIXED_FRACTION_W;
   localparam int N     = W + F;
   localparam int CNT_W = $clog2(N);

   typedef logic signed [W-1:0] fixed_point_t;

   localparam fixed_point_t FIXED_MAX = {1'b0, {(W-1){1'b1}}};
   localparam fixed_point_t FIXED_MIN = {1'b1, {(W-1){1'b0}}};

   // The magnitude of the most negative value is 2^(W-1), which still fits
   // in W bits once the result is treated as unsigned.
   function automatic logic [W-1:0] abs_mag(input fixed_point_t v);
      return v[W-1] ? -v : v;
   endfunction
endpackage

// File: rtl/fixed_point_div.sv
// Signed fixed-point divider with valid/ready handshakes on both sides.
// Uses restoring division, one quotient bit per cycle, and saturates on overflow.
module fixed_point_div
   import fixed_point_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  fixed_point_t dividend,
   input  fixed_point_t divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output fixed_point_t quotient,
   output logic         overflow,
   output logic         div_by_zero
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [N-1:0] POS_LIM = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [N-1:0] NEG_LIM = POS_LIM + 1'b1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [W-1:0]       rem_q, rem_d;
   logic [W-1:0]       dvsr_q, dvsr_d;
   logic [N-1:0]       num_q, num_d;   // numerator bits shift out, quotient bits shift in
   logic               sign_q, sign_d;
   fixed_point_t       quotient_q, quotient_d;
   logic               overflow_q, overflow_d;
   logic               dbz_q, dbz_d;

   logic [W:0]         rem_shift;
   logic               rem_ge;
   logic [N-1:0]       q_next;
   logic [W-1:0]       q_trunc;

   // NOTE: every _d gets a default first, so no path through the case leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rem_d      = rem_q;
      dvsr_d     = dvsr_q;
      num_d      = num_q;
      sign_d     = sign_q;
      quotient_d = quotient_q;
      overflow_d = overflow_q;
      dbz_d      = dbz_q;

      rem_shift = {rem_q, num_q[N-1]};
      rem_ge    = rem_shift >= {1'b0, dvsr_q};
      q_next    = {num_q[N-2:0], rem_ge};
      q_trunc   = q_next[W-1:0];

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  state_d    = DONE;
                  dbz_d      = 1'b1;
                  overflow_d = 1'b1;
                  quotient_d = dividend[W-1] ? FIXED_MIN : FIXED_MAX;
               end else begin
                  state_d = CALC;
                  count_d = '0;
                  rem_d   = '0;
                  dbz_d   = 1'b0;
                  sign_d  = dividend[W-1] ^ divisor[W-1];
                  dvsr_d  = abs_mag(divisor);
                  num_d   = {abs_mag(dividend), {F{1'b0}}};
               end
            end
         end
         CALC: begin
            rem_d   = rem_ge ? W'(rem_shift - {1'b0, dvsr_q}) : rem_shift[W-1:0];
            num_d   = q_next;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(N-1)) begin
               state_d    = DONE;
               overflow_d = sign_q ? (q_next > NEG_LIM) : (q_next > POS_LIM);
               if (overflow_d)
                  quotient_d = sign_q ? FIXED_MIN : FIXED_MAX;
               else
                  quotient_d = sign_q ? -q_trunc : q_trunc;
            end
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         num_q      <= '0;
         sign_q     <= 1'b0;
         quotient_q <= '0;
         overflow_q <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rem_q      <= rem_d;
         dvsr_q     <= dvsr_d;
         num_q      <= num_d;
         sign_q     <= sign_d;
         quotient_q <= quotient_d;
         overflow_q <= overflow_d;
         dbz_q      <= dbz_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quotient_q;
   assign overflow    = overflow_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/fixed_point_div.md
FIXED_POINT_DIV -- requirements
Module: fixed_point_div

Interface
REQ-001 SHALL have no parameters; widths come from the fixed_point package macros `FIXED_W (W) and `FIXED_FRACTION_W (F); N = W+F.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  operand pair valid.
REQ-005 in_ready  out  1  block can accept operands.
REQ-006 dividend  in  fixed_point_t  numerator, signed two's complement.
REQ-007 divisor  in  fixed_point_t  denominator, signed two's complement.
REQ-008 out_valid  out  1  result valid, held until consumed.
REQ-009 out_ready  in  1  consumer accepts result.
REQ-010 quotient  out  fixed_point_t  dividend/divisor, truncated toward zero, saturated on overflow.
REQ-011 overflow  out  1  true quotient not representable; quotient saturated.
REQ-012 div_by_zero  out  1  divisor was zero.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-015 Accept = in_valid & in_ready at a rising edge; operands captured at that edge, never sampled later.
REQ-016 On accept with divisor!=0: capture result sign = sign(dividend) ^ sign(divisor), unsigned magnitudes |dividend|, |divisor| (|-2^(W-1)| = 2^(W-1) as W-bit unsigned), numerator = |dividend| << F (N bits); state -> CALC, iteration count = 0.
REQ-017 CALC SHALL perform one restoring-division step per cycle (shift partial remainder left by one, bring in next numerator MSB, subtract |divisor| if remainder >= |divisor|, shift quotient bit in), N steps total.
REQ-018 After the Nth step state -> DONE; out_valid SHALL rise exactly N edges after the accepting edge.
REQ-019 Magnitude Q (N bits) overflows if Q > 2^(W-1)-1 for positive sign or Q > 2^(W-1) for negative sign.
REQ-020 No overflow: quotient = sign ? -Q : Q (W bits); Q==0 SHALL yield 0 regardless of sign.
REQ-021 Overflow: overflow=1, quotient = 2^(W-1)-1 (positive) or -2^(W-1) (negative).
REQ-022 On accept with divisor==0: state -> DONE directly (out_valid one edge after accept), div_by_zero=1, overflow=1, quotient = 2^(W-1)-1 if dividend>=0 else -2^(W-1).
REQ-023 In DONE, quotient/overflow/div_by_zero SHALL remain stable while out_ready=0; out_ready=1 -> IDLE next edge.
REQ-024 in_ready SHALL be 0 in CALC and DONE; in_valid there is ignored (no accept same cycle as result consume).
REQ-025 out_ready outside DONE SHALL have no effect.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, in_ready=1 after release, out_valid=0, quotient=0, overflow=0, div_by_zero=0, count=0, remainder=0.
REQ-027 rst mid-CALC or mid-DONE SHALL abort the operation; the pending result is discarded and never presented.

Structure
REQ-028 fixed_point package SHALL hold fixed_point_t, FIXED_MAX (2^(W-1)-1) and FIXED_MIN (-2^(W-1)) constants; the FSM state enum stays local to the module.
REQ-029 No sub-module; the restoring step and saturation logic are inline, single always_ff for state/datapath, combinational always_comb for step.

Verification (W=32, F=16, N=48)
REQ-030 6.0/2.0: 0x00060000 / 0x00020000 -> quotient 0x00030000, overflow=0, out_valid 48 edges after accept.
REQ-031 -1.5/0.5 and 1.0/3.0: 0xFFFE8000 / 0x00008000 -> 0xFFFD0000; 0x00010000 / 0x00030000 -> 0x00005555 (truncated).
REQ-032 Overflow: 0x40000000 / 0x00000100 -> 0x7FFFFFFF, overflow=1; 0x80000000 / 0xFFFF0000 -> 0x7FFFFFFF, overflow=1.
REQ-033 Divide by zero: 0xFFFF0000 / 0 -> quotient 0x80000000, div_by_zero=1, overflow=1, out_valid one edge after accept.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-035 Reset at step 20 of CALC -> out_valid never asserts, in_ready=1 after release, next operation 6.0/2.0 returns 0x00030000.
